// File: rtl/rc4_pkg.sv
// Shared RC4 types: byte width, default message length and the PRGA state encoding.
// The decryption FSM imports the same state enum.
package rc4_pkg;

  localparam int DATA_W      = 8;
  localparam int MSG_LEN_DEF = 32;

  typedef logic [DATA_W-1:0] byte_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INC_I,
    ST_WT_SI,
    ST_LT_SI,
    ST_RD_SJ,
    ST_WT_SJ,
    ST_LT_SJ,
    ST_WR_I,
    ST_WR_J,
    ST_RD_F,
    ST_WT_F,
    ST_WR_CT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rc4_encrypt_fsm.sv
// RC4 PRGA encryption engine: S RAM swaps, plaintext ROM in, ciphertext RAM out, 11 cycles/byte.
// Optional keystream drop phase enabled by defining RC4_DROP_EN (DROP_N iterations of 10 cycles).
module rc4_encrypt_fsm
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF,
  parameter int MSG_AW  = 5
`ifdef RC4_DROP_EN
  , parameter int DROP_N = 256
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [DATA_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_wren,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [MSG_AW-1:0] pt_addr,
  input  logic [DATA_W-1:0] pt_rdata,
  output logic [MSG_AW-1:0] ct_addr,
  output logic [DATA_W-1:0] ct_wdata,
  output logic              ct_wren,
  output logic              busy,
  output logic              done
);

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  state_e            state_q, state_d;
  byte_t             i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [MSG_AW-1:0] k_q, k_d;
  byte_t             s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic              s_wren_q, s_wren_d;
  logic [MSG_AW-1:0] pt_addr_q, pt_addr_d, ct_addr_q, ct_addr_d;
  byte_t             ct_wdata_q, ct_wdata_d;
  logic              ct_wren_q, ct_wren_d;
  logic              busy_q, busy_d, done_q, done_d;

`ifdef RC4_DROP_EN
  localparam int DCW = $clog2(DROP_N + 1);
  logic           drop_q, drop_d;
  logic [DCW-1:0] drop_cnt_q, drop_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    sj_d       = sj_q;
    k_d        = k_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_wren_d   = 1'b0;
    pt_addr_d  = pt_addr_q;
    ct_addr_d  = ct_addr_q;
    ct_wdata_d = ct_wdata_q;
    ct_wren_d  = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef RC4_DROP_EN
    drop_d     = drop_q;
    drop_cnt_d = drop_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        i_d = '0;
        j_d = '0;
        k_d = '0;
`ifdef RC4_DROP_EN
        drop_d     = (DROP_N != 0);
        drop_cnt_d = '0;
`endif
        if (start) begin
          busy_d  = 1'b1;
          state_d = ST_INC_I;
        end
      end
      // Address for S[i] is issued together with the increment.
      ST_INC_I: begin
        i_d      = i_q + byte_t'(1);
        s_addr_d = i_q + byte_t'(1);
        state_d  = ST_WT_SI;
      end
      ST_WT_SI: state_d = ST_LT_SI;
      ST_LT_SI: begin
        si_d    = s_rdata;
        j_d     = j_q + s_rdata;
        state_d = ST_RD_SJ;
      end
      ST_RD_SJ: begin
        s_addr_d = j_q;
        state_d  = ST_WT_SJ;
      end
      ST_WT_SJ: state_d = ST_LT_SJ;
      ST_LT_SJ: begin
        sj_d    = s_rdata;
        state_d = ST_WR_I;
      end
      ST_WR_I: begin
        s_addr_d  = i_q;
        s_wdata_d = sj_q;
        s_wren_d  = 1'b1;
        state_d   = ST_WR_J;
      end
      ST_WR_J: begin
        s_addr_d  = j_q;
        s_wdata_d = si_q;
        s_wren_d  = 1'b1;
        state_d   = ST_RD_F;
      end
      // The f read is issued only after the j write has reached the RAM.
      ST_RD_F: begin
        s_addr_d = si_q + sj_q;
`ifdef RC4_DROP_EN
        if (!drop_q) pt_addr_d = k_q;
`else
        pt_addr_d = k_q;
`endif
        state_d = ST_WT_F;
      end
      ST_WT_F: begin
`ifdef RC4_DROP_EN
        if (drop_q) begin
          drop_cnt_d = drop_cnt_q + DCW'(1);
          if (drop_cnt_q == DCW'(DROP_N - 1)) drop_d = 1'b0;
          state_d = ST_INC_I;
        end else begin
          state_d = ST_WR_CT;
        end
`else
        state_d = ST_WR_CT;
`endif
      end
      ST_WR_CT: begin
        ct_addr_d  = k_q;
        ct_wdata_d = s_rdata ^ pt_rdata;
        ct_wren_d  = 1'b1;
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + MSG_AW'(1);
          state_d = ST_INC_I;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      k_q        <= '0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wren_q   <= 1'b0;
      pt_addr_q  <= '0;
      ct_addr_q  <= '0;
      ct_wdata_q <= '0;
      ct_wren_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      k_q        <= k_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_wren_q   <= s_wren_d;
      pt_addr_q  <= pt_addr_d;
      ct_addr_q  <= ct_addr_d;
      ct_wdata_q <= ct_wdata_d;
      ct_wren_q  <= ct_wren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef RC4_DROP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wren   = s_wren_q;
  assign pt_addr  = pt_addr_q;
  assign ct_addr  = ct_addr_q;
  assign ct_wdata = ct_wdata_q;
  assign ct_wren  = ct_wren_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rc4_encrypt_fsm.sv
// Bench for rc4_encrypt_fsm: RAM/ROM models, plain RC4 reference and a ct-write scoreboard.
module tb_rc4_encrypt_fsm;
  import rc4_pkg::*;

  localparam int N  = 9;
  localparam int AW = 5;
`ifdef RC4_DROP_EN
  localparam int DROP = 2;
`else
  localparam int DROP = 0;
`endif
  localparam int LAT = 11 * N + 2 + 10 * DROP;

  typedef logic [AW+7:0] exp_t;

  logic        clk = 1'b0;
  logic        reset, start;
  byte_t       s_addr, s_wdata, s_rdata, pt_rdata, ct_wdata;
  logic        s_wren, ct_wren, busy, done;
  logic [AW-1:0] pt_addr, ct_addr;

  rc4_encrypt_fsm #(
    .MSG_LEN(N), .MSG_AW(AW)
`ifdef RC4_DROP_EN
    , .DROP_N(DROP)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
    .pt_addr(pt_addr), .pt_rdata(pt_rdata),
    .ct_addr(ct_addr), .ct_wdata(ct_wdata), .ct_wren(ct_wren),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  byte_t s_mem [256];
  byte_t pt_rom [32];
  byte_t ct_mem [32];
  byte_t ref_s [256];
  byte_t s_snap [256];
  byte_t key_buf [16];
  byte_t orig [N];
  int    key_len;
  logic  preload = 1'b0;
  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;
  exp_t  exp_q [$];

  // Memories: one registered read per edge, writes land on the same edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload) begin
      for (int a = 0; a < 256; a++) s_mem[a] <= ref_s[a];
    end else if (s_wren) begin
      s_mem[s_addr] <= s_wdata;
    end
    s_rdata  <= s_mem[s_addr];
    pt_rdata <= pt_rom[pt_addr];
    if (ct_wren) ct_mem[ct_addr] <= ct_wdata;
  end

  always @(negedge clk) begin
    if (!reset && ct_wren) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL ct_write_unexpected addr=%0d data=%02h required=none", ct_addr, ct_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({ct_addr, ct_wdata} !== e)
          begin
            fails++;
            $display("FAIL ct_write actual addr=%0d data=%02h required addr=%0d data=%02h",
                     ct_addr, ct_wdata, e[AW+7:8], e[7:0]);
          end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void set_key_str(input string s);
    key_len = s.len();
    for (int a = 0; a < key_len; a++) key_buf[a] = byte_t'(s[a]);
  endfunction

  function automatic void set_pt_str(input string s);
    for (int a = 0; a < s.len(); a++) pt_rom[a] = byte_t'(s[a]);
  endfunction

  function automatic void ksa();
    int    j;
    byte_t t;
    j = 0;
    for (int a = 0; a < 256; a++) ref_s[a] = byte_t'(a);
    for (int a = 0; a < 256; a++) begin
      j = (j + int'(ref_s[a]) + int'(key_buf[a % key_len])) & 255;
      t = ref_s[a]; ref_s[a] = ref_s[j]; ref_s[j] = t;
    end
  endfunction

  // Plain RC4 PRGA from i=j=0 on the current S; pushes the expected ct writes.
  function automatic void model_run();
    int    i, j;
    byte_t t, ks;
    i = 0;
    j = 0;
    for (int n = 0; n < DROP + N; n++) begin
      i = (i + 1) & 255;
      j = (j + int'(ref_s[i])) & 255;
      t = ref_s[i]; ref_s[i] = ref_s[j]; ref_s[j] = t;
      ks = ref_s[(int'(ref_s[i]) + int'(ref_s[j])) & 255];
      if (n >= DROP) exp_q.push_back({AW'(n - DROP), pt_rom[n - DROP] ^ ks});
    end
  endfunction

  task automatic do_preload();
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
  endtask

  // Raise start for one cycle (optionally pulse it again mid-run) and time done.
  task automatic run(input string name, input bit pulse_mid);
    int p;
    bit seen;
    seen  = 1'b0;
    start = 1'b1;
    p     = cyc;
    while (!seen && cyc < p + 3000) begin
      @(posedge clk); #1;
      start = pulse_mid && (cyc - p == 40);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end else begin
      check({name, "_latency"}, cyc - p, LAT);
    end
    @(posedge clk); #1;
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_key_vector(input string name);
`ifndef RC4_DROP_EN
    byte_t v [9];
    v = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int a = 0; a < 9; a++) check($sformatf("%s_ct%0d", name, a), ct_mem[a], v[a]);
`else
    check({name, "_busy_idle"}, busy, 0);
`endif
  endtask

  task automatic key_run(input string name, input bit pulse_mid);
    set_key_str("Key");
    ksa();
    do_preload();
    set_pt_str("Plaintext");
    model_run();
    run(name, pulse_mid);
    check_key_vector(name);
  endtask

  initial begin
    int p;
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s_wren", s_wren, 0);
    check("rst_ct_wren", ct_wren, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_wdata", s_wdata, 0);
    check("rst_pt_addr", pt_addr, 0);
    check("rst_ct_addr", ct_addr, 0);
    check("rst_ct_wdata", ct_wdata, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    key_run("key", 1'b0);

    set_key_str("Wiki");
    ksa();
    do_preload();
    set_pt_str("pedia");
    for (int a = 5; a < N; a++) pt_rom[a] = byte_t'($urandom);
    model_run();
    run("wiki", 1'b0);
`ifndef RC4_DROP_EN
    begin
      byte_t w [5];
      w = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
      for (int a = 0; a < 5; a++) check($sformatf("wiki_ct%0d", a), ct_mem[a], w[a]);
    end
`endif

    // Loopback and random keys: the same engine decrypts with the same S.
    for (int r = 0; r < 3; r++) begin
      key_len = $urandom_range(16, 1);
      for (int a = 0; a < key_len; a++) key_buf[a] = byte_t'($urandom);
      ksa();
      s_snap = ref_s;
      do_preload();
      for (int a = 0; a < N; a++) begin
        pt_rom[a] = byte_t'($urandom);
        orig[a]   = pt_rom[a];
      end
      model_run();
      run("enc", 1'b0);
      for (int a = 0; a < N; a++) pt_rom[a] = ct_mem[a];
      ref_s = s_snap;
      do_preload();
      model_run();
      run("dec", 1'b0);
      for (int a = 0; a < N; a++) check($sformatf("loop%0d_pt%0d", r, a), ct_mem[a], orig[a]);
    end

    key_run("pulse_busy", 1'b1);

    // start held across done: second run continues on the swapped S with i=j=0.
    set_key_str("Key");
    ksa();
    do_preload();
    set_pt_str("Plaintext");
    model_run();
    model_run();
    start = 1'b1;
    p     = cyc;
    seen  = 1'b0;
    while (!seen && cyc < p + 3000) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("hold_first_done", seen, 1);
    check("hold_first_latency", cyc - p, LAT);
    check("hold_busy_gap", busy, 0);
    p = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_busy_back", busy, 1);
    seen = 1'b0;
    while (!seen && cyc < p + 3000) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("hold_second_done", seen, 1);
    check("hold_second_latency", cyc - p, LAT);
    @(posedge clk); #1;
    check("hold_drained", exp_q.size(), 0);
    exp_q.delete();

    // Reset in the middle of a run.
    set_key_str("Key");
    ksa();
    do_preload();
    set_pt_str("Plaintext");
    model_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (38) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_s_wren", s_wren, 0);
    check("midrst_ct_wren", ct_wren, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("midrst_idle_busy", busy, 0);
    key_run("after_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
